// File: rtl/regfile_sb_if.sv
// Register-file bus: two read ports, destination reservation and write-back.
interface regfile_sb_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              re1_i;
    logic [ADDR_W-1:0] raddr1_i;
    logic [DATA_W-1:0] rdata1_o;
    logic              suc1_o;
    logic              re2_i;
    logic [ADDR_W-1:0] raddr2_i;
    logic [DATA_W-1:0] rdata2_o;
    logic              suc2_o;
    logic              rsv_i;
    logic [ADDR_W-1:0] rsv_addr_i;
    logic              rsv_ready_o;
    logic              we_i;
    logic [ADDR_W-1:0] waddr_i;
    logic [DATA_W-1:0] wdata_i;
    logic              flush_i;

    modport slave (
        input  re1_i, raddr1_i, re2_i, raddr2_i,
        input  rsv_i, rsv_addr_i, we_i, waddr_i, wdata_i, flush_i,
        output rdata1_o, suc1_o, rdata2_o, suc2_o, rsv_ready_o
    );

    modport master (
        output re1_i, raddr1_i, re2_i, raddr2_i,
        output rsv_i, rsv_addr_i, we_i, waddr_i, wdata_i, flush_i,
        input  rdata1_o, suc1_o, rdata2_o, suc2_o, rsv_ready_o
    );
endinterface

// File: rtl/regfile_sb.sv
// Scoreboarded integer register file: per-register pending counters gate
// operand validity, with same-cycle write-back bypass on both read ports.
module regfile_sb #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned PEND_W = 2
) (
    input logic         clk,
    input logic         rst,
    regfile_sb_if.slave bus
);
    localparam int unsigned NREG = 2 ** ADDR_W;
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    logic [DATA_W-1:0] mem_q  [NREG];
    logic [PEND_W-1:0] pend_q [NREG];
    logic [PEND_W-1:0] pend_d [NREG];

    logic              hit1, hit2;
    logic [DATA_W-1:0] rdata1, rdata2;
    logic              suc1, suc2;
    logic              rsv_ready;
    logic              wr_en;

    assign wr_en = bus.we_i && (bus.waddr_i != '0);

    // Read ports; reset forces the idle response regardless of inputs.
    always_comb begin
        hit1   = 1'b0;
        hit2   = 1'b0;
        rdata1 = '0;
        rdata2 = '0;
        suc1   = 1'b1;
        suc2   = 1'b1;
        if (rst && bus.re1_i && (bus.raddr1_i != '0)) begin
            hit1   = bus.we_i && (bus.waddr_i == bus.raddr1_i);
            rdata1 = hit1 ? bus.wdata_i : mem_q[bus.raddr1_i];
            suc1   = (pend_q[bus.raddr1_i] == '0) ||
                     ((pend_q[bus.raddr1_i] == PEND_ONE) && hit1);
        end
        if (rst && bus.re2_i && (bus.raddr2_i != '0)) begin
            hit2   = bus.we_i && (bus.waddr_i == bus.raddr2_i);
            rdata2 = hit2 ? bus.wdata_i : mem_q[bus.raddr2_i];
            suc2   = (pend_q[bus.raddr2_i] == '0) ||
                     ((pend_q[bus.raddr2_i] == PEND_ONE) && hit2);
        end
    end

    // A saturated counter can still take a reservation if a write-back frees a slot.
    always_comb begin
        rsv_ready = 1'b0;
        if (rst) begin
            rsv_ready = (bus.rsv_addr_i == '0) ||
                        (pend_q[bus.rsv_addr_i] != PEND_MAX) ||
                        (bus.we_i && (bus.waddr_i == bus.rsv_addr_i));
        end
    end

    assign bus.rdata1_o    = rdata1;
    assign bus.rdata2_o    = rdata2;
    assign bus.suc1_o      = suc1;
    assign bus.suc2_o      = suc2;
    assign bus.rsv_ready_o = rsv_ready;

    // Counter next state: reserve and release on the same register cancel; flush wins.
    always_comb begin
        logic inc;
        logic dec;
        inc = 1'b0;
        dec = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            pend_d[i] = pend_q[i];
            inc = (i != 0) && bus.rsv_i && rsv_ready && (bus.rsv_addr_i == ADDR_W'(i));
            dec = (i != 0) && bus.we_i && (bus.waddr_i == ADDR_W'(i));
            if (inc && !dec) begin
                pend_d[i] = pend_q[i] + PEND_ONE;
            end else if (dec && !inc && (pend_q[i] != '0)) begin
                pend_d[i] = pend_q[i] - PEND_ONE;
            end
            if (bus.flush_i) begin
                pend_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i]  <= '0;
                pend_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                pend_q[i] <= pend_d[i];
            end
            if (wr_en) begin
                mem_q[bus.waddr_i] <= bus.wdata_i;
            end
        end
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed scoreboard bench for regfile_sb: expectations queued per step,
// drained and checked against the combinational outputs mid-cycle.
module tb_regfile_sb;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    string       tag_q[$];
    int          sel_q[$];
    logic [31:0] exp_q[$];

    regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .PEND_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int RD1 = 0, SUC1 = 1, RD2 = 2, SUC2 = 3, RDY = 4;

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            RD1:     return bus.rdata1_o;
            SUC1:    return {31'b0, bus.suc1_o};
            RD2:     return bus.rdata2_o;
            SUC2:    return {31'b0, bus.suc2_o};
            default: return {31'b0, bus.rsv_ready_o};
        endcase
    endfunction

    task automatic clear_inputs();
        bus.re1_i = 1'b0; bus.raddr1_i = '0;
        bus.re2_i = 1'b0; bus.raddr2_i = '0;
        bus.rsv_i = 1'b0; bus.rsv_addr_i = '0;
        bus.we_i = 1'b0; bus.waddr_i = '0; bus.wdata_i = '0;
        bus.flush_i = 1'b0;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic expect_val(input string tag, input int sel, input logic [31:0] v);
        tag_q.push_back(tag);
        sel_q.push_back(sel);
        exp_q.push_back(v);
    endtask

    task automatic rd1(input logic [4:0] a);
        bus.re1_i = 1'b1; bus.raddr1_i = a;
    endtask

    task automatic rd2(input logic [4:0] a);
        bus.re2_i = 1'b1; bus.raddr2_i = a;
    endtask

    task automatic rsv(input logic [4:0] a);
        bus.rsv_i = 1'b1; bus.rsv_addr_i = a;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        bus.we_i = 1'b1; bus.waddr_i = a; bus.wdata_i = d;
    endtask

    // Let combinational outputs settle, then drain the scoreboard.
    task automatic check_all();
        string       t;
        int          s;
        logic [31:0] e;
        logic [31:0] o;
        #1;
        while (tag_q.size() > 0) begin
            t = tag_q.pop_front();
            s = sel_q.pop_front();
            e = exp_q.pop_front();
            o = observe(s);
            total++;
            assert (o === e) else begin
                bad++;
                $error("FAIL %s got=%h want=%h", t, o, e);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        clear_inputs();

        // Held in reset: bypass and reservation must be suppressed.
        next_cycle();
        next_cycle();
        rd1(5'd5); wb(5'd5, 32'h1); rsv(5'd3);
        expect_val("rst_rdata1", RD1, 32'h0);
        expect_val("rst_suc1", SUC1, 32'h1);
        expect_val("rst_ready", RDY, 32'h0);
        check_all();
        next_cycle();
        rst = 1'b1;

        // Plain write and read-back, x0 on port 2.
        next_cycle();
        wb(5'd5, 32'h1234); rd1(5'd5);
        expect_val("wr5_bypass", RD1, 32'h1234);
        check_all();
        next_cycle();
        rd1(5'd5); rd2(5'd0);
        expect_val("rd5_data", RD1, 32'h1234);
        expect_val("rd5_suc", SUC1, 32'h1);
        expect_val("rd0_data", RD2, 32'h0);
        expect_val("rd0_suc", SUC2, 32'h1);
        expect_val("ready_x0", RDY, 32'h1);
        check_all();

        // Reserve x7, stall, then release with bypass.
        next_cycle();
        rsv(5'd7); rd1(5'd7);
        expect_val("rsv7_ready", RDY, 32'h1);
        expect_val("rsv7_suc_same", SUC1, 32'h1);
        check_all();
        next_cycle();
        rd1(5'd7);
        expect_val("x7_pending", SUC1, 32'h0);
        check_all();
        next_cycle();
        rd1(5'd7); wb(5'd7, 32'hDEAD);
        expect_val("x7_byp_data", RD1, 32'hDEAD);
        expect_val("x7_byp_suc", SUC1, 32'h1);
        check_all();
        next_cycle();
        rd1(5'd7);
        expect_val("x7_after_data", RD1, 32'hDEAD);
        expect_val("x7_after_suc", SUC1, 32'h1);
        check_all();

        // Saturate x3.
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            rsv(5'd3); rd2(5'd3);
            expect_val("x3_rsv_ready", RDY, 32'h1);
            expect_val("x3_rsv_suc", SUC2, (k == 0) ? 32'h1 : 32'h0);
            check_all();
        end
        next_cycle();
        rsv(5'd3); rd2(5'd3);
        expect_val("x3_sat_ready", RDY, 32'h0);
        expect_val("x3_sat_suc", SUC2, 32'h0);
        check_all();
        // Saturated but released this cycle: accepted, counter stays at 3.
        next_cycle();
        rsv(5'd3); wb(5'd3, 32'h30); rd1(5'd3);
        expect_val("x3_sat_wb_ready", RDY, 32'h1);
        expect_val("x3_sat_wb_data", RD1, 32'h30);
        expect_val("x3_sat_wb_suc", SUC1, 32'h0);
        check_all();
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            wb(5'd3, 32'h31 + 32'(k)); rd1(5'd3);
            expect_val("x3_drain_data", RD1, 32'h31 + 32'(k));
            expect_val("x3_drain_suc", SUC1, (k == 2) ? 32'h1 : 32'h0);
            check_all();
        end
        next_cycle();
        rd1(5'd3);
        expect_val("x3_final_data", RD1, 32'h33);
        expect_val("x3_final_suc", SUC1, 32'h1);
        check_all();

        // Same-register reserve and write-back leaves counter at 1.
        next_cycle();
        rsv(5'd9);
        check_all();
        next_cycle();
        rsv(5'd9); wb(5'd9, 32'h99); rd1(5'd9);
        expect_val("x9_same_suc", SUC1, 32'h1);
        check_all();
        next_cycle();
        rd1(5'd9);
        expect_val("x9_next_data", RD1, 32'h99);
        expect_val("x9_next_suc", SUC1, 32'h0);
        check_all();

        // Flush clears all counters, overrides reserve, keeps array write.
        next_cycle();
        rsv(5'd4);
        check_all();
        next_cycle();
        rsv(5'd6);
        check_all();
        next_cycle();
        rsv(5'd8); bus.flush_i = 1'b1; wb(5'd12, 32'hC); rd1(5'd4); rd2(5'd6);
        expect_val("flush_x4_pre", SUC1, 32'h0);
        expect_val("flush_x6_pre", SUC2, 32'h0);
        check_all();
        next_cycle();
        rd1(5'd4); rd2(5'd6);
        expect_val("flush_x4", SUC1, 32'h1);
        expect_val("flush_x6", SUC2, 32'h1);
        check_all();
        next_cycle();
        rd1(5'd8); rd2(5'd9);
        expect_val("flush_x8", SUC1, 32'h1);
        expect_val("flush_x9", SUC2, 32'h1);
        check_all();
        next_cycle();
        rd1(5'd12);
        expect_val("flush_wb_x12", RD1, 32'hC);
        check_all();

        // Asynchronous reset pulse between edges.
        next_cycle();
        wb(5'd10, 32'h55);
        check_all();
        next_cycle();
        rsv(5'd10);
        check_all();
        next_cycle();
        rsv(5'd10);
        check_all();
        next_cycle();
        rd1(5'd10); bus.rsv_addr_i = 5'd10;
        expect_val("x10_pre_data", RD1, 32'h55);
        expect_val("x10_pre_suc", SUC1, 32'h0);
        check_all();
        #1 rst = 1'b0;
        expect_val("x10_rst_data", RD1, 32'h0);
        expect_val("x10_rst_suc", SUC1, 32'h1);
        expect_val("x10_rst_ready", RDY, 32'h0);
        check_all();
        rst = 1'b1;
        next_cycle();
        rd1(5'd10); rsv(5'd10);
        expect_val("x10_post_data", RD1, 32'h0);
        expect_val("x10_post_suc", SUC1, 32'h1);
        expect_val("x10_post_ready", RDY, 32'h1);
        check_all();
        next_cycle();
        rd1(5'd10); wb(5'd10, 32'h77);
        expect_val("x10_wb_data", RD1, 32'h77);
        expect_val("x10_wb_suc", SUC1, 32'h1);
        check_all();
        next_cycle();
        rd1(5'd10);
        expect_val("x10_final_data", RD1, 32'h77);
        expect_val("x10_final_suc", SUC1, 32'h1);
        check_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
